// File: rtl/seq_gen_pkg.sv
// Shared types for the multi-mode sequence generator: FSM states and mode encodings.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_FIB = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQR = 2'd2,
        MODE_POW = 2'd3
    } mode_t;

    // States in which a run is in progress and start/update are ignored.
    function automatic logic run_active(input state_t s);
        return (s == EMIT) || (s == WAIT);
    endfunction

endpackage

// File: rtl/seq_gen_multi_tick_div.sv
// Loadable down-counter used as the inter-term prescaler; holds at zero once expired.
module tick_div #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         freeze,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down unless frozen or already at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!freeze && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/seq_gen_multi.sv
// Multi-mode sequence generator (Fibonacci, triangular, squares, powers of two)
// with programmable term period, valid/ready output, sticky overflow and transfer count.
module seq_gen_multi
    import seq_gen_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PROG_W   = 3,
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              update,
    input  logic [PROG_W-1:0] prog,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stop,
    input  logic              ready,
    output logic [WIDTH-1:0]  value,
    output logic              valid,
    output logic              busy,
    output logic              ovf,
    output logic              parity,
    output logic [CNT_W-1:0]  count
);

    localparam int DIV_W = PROG_W + $clog2(TICK_DIV) + 1;

    state_t             state;
    mode_t              mode_q;
    logic [PROG_W-1:0]  prog_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   curr_q;
    logic [WIDTH-1:0]   n_q;
    logic [CNT_W-1:0]   count_q;
    logic               valid_q;
    logic               busy_q;
    logic               ovf_q;

    logic [WIDTH:0]     next_term;
    logic               carry;
    logic               xfer;
    logic [DIV_W-1:0]   period;
    logic               period_one;
    logic               div_load;
    logic [DIV_W-1:0]   div_val;
    logic               div_freeze;
    logic               div_expired;

    // Successor of the current term, one bit wider than a term so a carry flags overflow.
    always_comb begin
        next_term = '0;
        case (mode_q)
            MODE_FIB: next_term = {1'b0, prev_q} + {1'b0, curr_q};
            MODE_TRI: next_term = {1'b0, curr_q} + {1'b0, n_q} + (WIDTH+1)'(1);
            MODE_SQR: next_term = {1'b0, curr_q} + {n_q, 1'b0} + (WIDTH+1)'(1);
            MODE_POW: next_term = {curr_q, 1'b0};
            default:  next_term = '0;
        endcase
    end

    assign carry = next_term[WIDTH];
    assign xfer  = (state == EMIT) && ready;

    // Term period in cycles; the prescaler covers the P-1 cycles between handshake and next valid.
    always_comb begin
        period     = (DIV_W'(prog_q) + DIV_W'(1)) * DIV_W'(TICK_DIV);
        period_one = (period == DIV_W'(1));
        div_val    = period - DIV_W'(2);
        div_load   = xfer && !stop && !carry && !period_one;
        div_freeze = (state != WAIT);
    end

    tick_div #(
        .W (DIV_W)
    ) u_tick_div (
        .clock    (clock),
        .reset    (reset),
        .load     (div_load),
        .load_val (div_val),
        .freeze   (div_freeze),
        .expired  (div_expired)
    );

    // Main control FSM; valid and busy are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= MODE_FIB;
            prog_q  <= '0;
            prev_q  <= '0;
            curr_q  <= '0;
            n_q     <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (update) begin
                        prog_q <= prog;
                    end
                    if (start && !stop) begin
                        mode_q  <= mode_t'(mode);
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        n_q     <= '0;
                        // Fibonacci seeds prev=1 so the first successor of 0 is 1.
                        case (mode_t'(mode))
                            MODE_FIB: begin
                                prev_q <= WIDTH'(1);
                                curr_q <= '0;
                            end
                            MODE_POW: begin
                                prev_q <= '0;
                                curr_q <= WIDTH'(1);
                            end
                            default: begin
                                prev_q <= '0;
                                curr_q <= '0;
                            end
                        endcase
                        state   <= EMIT;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                EMIT: begin
                    if (ready) begin
                        count_q <= count_q + CNT_W'(1);
                        if (stop) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else if (carry) begin
                            state   <= DONE;
                            ovf_q   <= 1'b1;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            prev_q <= curr_q;
                            curr_q <= next_term[WIDTH-1:0];
                            n_q    <= n_q + WIDTH'(1);
                            if (period_one) begin
                                state   <= EMIT;
                                valid_q <= 1'b1;
                            end else begin
                                state   <= WAIT;
                                valid_q <= 1'b0;
                            end
                        end
                    end else if (stop) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                WAIT: begin
                    if (stop) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (div_expired) begin
                        state   <= EMIT;
                        valid_q <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= run_active(IDLE);
                end
            endcase
        end
    end

    assign value  = curr_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign ovf    = ovf_q;
    assign count  = count_q;
    assign parity = ^curr_q;

endmodule

// File: tb/tb_seq_gen_multi.sv
// Self-checking bench for seq_gen_multi (WIDTH=8, TICK_DIV=1, CNT_W=8).
module tb_seq_gen_multi;

    localparam int WIDTH  = 8;
    localparam int PROG_W = 3;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              update = 1'b0;
    logic [PROG_W-1:0] prog = '0;
    logic              start = 1'b0;
    logic [1:0]        mode = '0;
    logic              stop = 1'b0;
    logic              ready = 1'b0;
    logic [WIDTH-1:0]  value;
    logic              valid;
    logic              busy;
    logic              ovf;
    logic              parity;
    logic [CNT_W-1:0]  count;

    seq_gen_multi #(
        .WIDTH    (WIDTH),
        .PROG_W   (PROG_W),
        .TICK_DIV (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .update (update),
        .prog   (prog),
        .start  (start),
        .mode   (mode),
        .stop   (stop),
        .ready  (ready),
        .value  (value),
        .valid  (valid),
        .busy   (busy),
        .ovf    (ovf),
        .parity (parity),
        .count  (count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_xfer = -1;
    int exp_gap = 0;
    int exp_q[$];

    typedef struct {
        int mode;
        int prog;
        int terms;
        int last;
    } vec_t;

    vec_t vec[5];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int term(input int m, input int k);
        int a, b, t;
        a = 0;
        b = 1;
        case (m)
            0: begin
                for (int i = 0; i < k; i++) begin
                    t = a + b;
                    a = b;
                    b = t;
                end
                return a;
            end
            1: return k * (k + 1) / 2;
            2: return k * k;
            default: return 1 << k;
        endcase
    endfunction

    // Scoreboard: every handshake pops one expected term and checks value, parity and spacing.
    always @(negedge clock) begin
        int e;
        #1;
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_xfer: got value %0d, expected no transfer", value);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_value", 32'(value), e);
                chk("xfer_parity", 32'(parity), 32'(^e[7:0]));
                if (last_xfer >= 0 && exp_gap > 0)
                    chk("xfer_gap", cyc - last_xfer, exp_gap);
                last_xfer = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push_terms(input int m, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(term(m, k));
    endtask

    task automatic start_run(input int m, input int p, input int n, input int gap);
        update = 1'b1;
        prog = PROG_W'(p);
        tick();
        update = 1'b0;
        push_terms(m, n);
        exp_gap = gap;
        last_xfer = -1;
        start = 1'b1;
        mode = 2'(m);
        tick();
        start = 1'b0;
        chk("start_valid", 32'(valid), 1);
        chk("start_ovf_clear", 32'(ovf), 0);
        chk("start_count_clear", 32'(count), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 0);
    endtask

    // Advance until valid is high with the given value (or, if want_valid=0, low with it).
    task automatic wait_value(input string name, input int v, input logic want_valid, input int budget);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            if (busy && valid == want_valid && int'(value) == v) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk(name, 32'(found), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        vec[0] = '{mode: 0, prog: 3, terms: 14, last: 233};
        vec[1] = '{mode: 0, prog: 0, terms: 14, last: 233};
        vec[2] = '{mode: 2, prog: 0, terms: 16, last: 225};
        vec[3] = '{mode: 1, prog: 1, terms: 23, last: 253};
        vec[4] = '{mode: 3, prog: 2, terms: 8,  last: 128};

        // Reset held for three cycles.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_value", 32'(value), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_parity", 32'(parity), 0);
        reset = 1'b0;
        tick();

        // Full runs to overflow, ready held high.
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_run(vec[i].mode, vec[i].prog, vec[i].terms, vec[i].prog + 1);
            wait_idle("run_done_timeout", 2000);
            chk("run_ovf", 32'(ovf), 1);
            chk("run_valid", 32'(valid), 0);
            chk("run_value", 32'(value), vec[i].last);
            chk("run_count", 32'(count), vec[i].terms);
            chk("run_queue_empty", exp_q.size(), 0);
        end

        // Triangular with backpressure while value=3, then stop together with ready on value=10.
        ready = 1'b1;
        start_run(1, 0, 5, 0);
        wait_value("tri_reach3", 3, 1'b1, 100);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("tri_hold_value", 32'(value), 3);
            chk("tri_hold_valid", 32'(valid), 1);
        end
        ready = 1'b1;
        wait_value("tri_reach10", 10, 1'b1, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("tri_stop_valid", 32'(valid), 0);
        chk("tri_stop_busy", 32'(busy), 0);
        chk("tri_stop_value", 32'(value), 10);
        chk("tri_stop_count", 32'(count), 5);
        chk("tri_queue_empty", exp_q.size(), 0);

        // Powers of two, stop while the prescaler runs with value=4.
        start_run(3, 3, 2, 4);
        wait_value("pow_reach4", 4, 1'b0, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pow_stop_valid", 32'(valid), 0);
        chk("pow_stop_busy", 32'(busy), 0);
        chk("pow_stop_value", 32'(value), 4);
        chk("pow_stop_count", 32'(count), 2);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (valid || busy) seen = 1'b1;
        end
        chk("pow_stays_idle", 32'(seen), 0);
        chk("pow_queue_empty", exp_q.size(), 0);

        // start and stop in the same cycle: no run begins, count untouched.
        start = 1'b1;
        stop = 1'b1;
        mode = 2'd0;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", 32'(busy), 0);
        chk("ss_valid", 32'(valid), 0);
        repeat (3) tick();
        chk("ss_busy_later", 32'(busy), 0);
        chk("ss_count", 32'(count), 2);

        // Reset during EMIT with value=21, then a fresh start runs at period 1.
        start_run(0, 5, 8, 6);
        wait_value("fib_reach21", 21, 1'b1, 200);
        ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_value", 32'(value), 0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ovf", 32'(ovf), 0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_parity", 32'(parity), 0);
        chk("mrst_queue_empty", exp_q.size(), 0);
        push_terms(0, 4);
        exp_gap = 1;
        last_xfer = -1;
        ready = 1'b1;
        start = 1'b1;
        mode = 2'd0;
        tick();
        start = 1'b0;
        wait_value("post_rst_reach2", 2, 1'b1, 50);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("post_rst_count", 32'(count), 4);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_gen_multi.md
# seq_gen_multi

Parametrised sequence generator, successor to the fixed Fibonacci/triangular generator in the board top level. It generalises term width and adds two sequence modes (squares, powers of two), a programmable term rate, valid/ready backpressure, overflow detection and a transfer counter. It sits between the button/switch decode logic and the LED and 7-segment display path, feeding terms one at a time to the display buffer.

## Interface
- WIDTH, 16, term width in bits (≥4)
- PROG_W, 3, width of the rate program word
- TICK_DIV, 1, base cycles per rate step (≥1)
- CNT_W, 8, width of the transfer counter

- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- update  in  1  one-cycle pulse; loads prog into prog_q
- prog  in  PROG_W  rate program word
- start  in  1  one-cycle pulse; begins the sequence selected by mode
- mode  in  2  0 Fibonacci, 1 triangular, 2 squares, 3 powers of two; sampled on accepted start
- stop  in  1  one-cycle pulse; aborts the run
- ready  in  1  consumer accepts value when high
- value  out  WIDTH  current term
- valid  out  1  value holds an untransferred term
- busy  out  1  high in EMIT or WAIT
- ovf  out  1  sticky; next term did not fit in WIDTH
- parity  out  1  XOR-reduce of value
- count  out  CNT_W  terms transferred since last start; wraps modulo 2^CNT_W

## Operation
- States: IDLE, EMIT (valid=1), WAIT (prescaler running), DONE.
- Reset: state IDLE; value, count, prog_q, mode_q, ovf = 0; valid = busy = 0; parity = 0.
- update accepted only in IDLE or DONE; ignored in EMIT/WAIT.
- start accepted in IDLE or DONE: latch mode_q, clear ovf and count, load first term, go EMIT. Ignored in EMIT/WAIT.
- Sequences, n = index of term: Fibonacci 0,1,1,2,3,5…; triangular 0,1,3,6,10… (T(n)=T(n-1)+n); squares 0,1,4,9… (S(n)=S(n-1)+2n-1); powers of two 1,2,4,8….
- Next term computed in WIDTH+1 bits. Handshake in EMIT (valid & ready): count increments; if next term carries out of WIDTH → ovf=1, go DONE, value holds last transferred term; otherwise value ← next term, go WAIT (or EMIT directly when the period is 1).
- WAIT: down-counter; on expiry go EMIT.
- stop in EMIT/WAIT → IDLE, valid drops, value holds. stop in EMIT with ready=1 in the same cycle: the transfer completes (count increments), then IDLE.
- start and stop in the same cycle: stop wins; no run starts.
- DONE: valid=0, busy=0, ovf=1 until the next start or reset.
- parity is combinational from registered value.

## Timing
- start at cycle t → valid=1, value=first term at t+1.
- Period P = (prog_q+1)·TICK_DIV cycles. Handshake at cycle t → next valid rises at t+P, provided no stall.
- valid & !ready: value and valid held stable, prescaler frozen; there is no term loss or duplication.
- P=1 with ready held high gives one term per cycle.
- ovf and DONE are visible the cycle after the overflowing handshake.
- Reset mid-run takes effect the next edge; all outputs return to their reset values.

## Structure
- Package seq_gen_pkg: state enum (IDLE/EMIT/WAIT/DONE), mode encodings (MODE_FIB=0, MODE_TRI=1, MODE_SQR=2, MODE_POW=3).
- One sub-module tick_div: loadable down-counter of width PROG_W+clog2(TICK_DIV)+1, with a freeze input and an expiry flag.
- Next-term arithmetic is an inline combinational case on mode_q, using registered prev, curr and n.

## Test plan (WIDTH=8, TICK_DIV=1, CNT_W=8)
- Reset held 3 cycles → value=0, valid=0, busy=0, ovf=0, count=0, parity=0.
- update prog=3, start mode=0, ready=1 → values 0,1,1,2,3,5,8,13 with valid rising every 4 cycles; at 13 parity=1.
- Fibonacci, prog=0, ready=1 → 14 terms through 233, then ovf=1, DONE, value=233, count=14. Squares → 16 terms through 225, ovf=1.
- Triangular, ready low 5 cycles while value=3 → value=3 and valid=1 held; next transfers are 6 and 10, with no term skipped.
- Powers of two, stop during WAIT after value=4 → next cycle valid=0, busy=0, value=4. start+stop in the same cycle → stays IDLE.
- Reset asserted in EMIT with value=21 → next cycle all outputs 0 and prog_q=0. A following start gives a period of 1.
